// File: rtl/change_dispenser.sv
// Greedy coin-change dispenser: latches a balance, presents the largest fitting coin
// each cycle until the downstream ejector accepts it, then reports the undispensable residue.
module change_dispenser #(
    parameter  int unsigned kCoin0Value = 100,
    parameter  int unsigned kCoin1Value = 500,
    parameter  int unsigned kCoin2Value = 1000,
    localparam int unsigned kNumCoins   = 3,
    localparam int unsigned kBalW       = 31
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_start,
    input  logic [kBalW-1:0]     i_balance,
    input  logic                 i_ready,
    output logic [kNumCoins-1:0] o_return_coin,
    output logic                 o_valid,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [kBalW-1:0]     o_residue
);

    localparam logic [kBalW-1:0] kC0 = kBalW'(kCoin0Value);
    localparam logic [kBalW-1:0] kC1 = kBalW'(kCoin1Value);
    localparam logic [kBalW-1:0] kC2 = kBalW'(kCoin2Value);

    typedef enum logic [1:0] {
        IDLE,
        DISPENSE,
        DONE
    } state_t;

    state_t               state;
    state_t               state_nx;
    logic [kBalW-1:0]     remaining;
    logic [kBalW-1:0]     remaining_nx;
    logic [kBalW-1:0]     residue_nx;
    logic [kBalW-1:0]     coin_val;
    logic [kNumCoins-1:0] coin_nx;
    logic                 valid_nx;
    logic                 busy_nx;
    logic                 done_nx;

    // Value of the coin currently on the bus; only meaningful while o_valid is set.
    always_comb begin
        coin_val = '0;
        if (o_return_coin[2]) begin
            coin_val = kC2;
        end else if (o_return_coin[1]) begin
            coin_val = kC1;
        end else if (o_return_coin[0]) begin
            coin_val = kC0;
        end
    end

    // Next-state logic; outputs are precomputed from the next state so they leave registers.
    always_comb begin
        state_nx     = state;
        remaining_nx = remaining;
        residue_nx   = o_residue;
        coin_nx      = '0;
        valid_nx     = 1'b0;
        busy_nx      = 1'b0;
        done_nx      = 1'b0;

        case (state)
            IDLE: begin
                if (i_start) begin
                    remaining_nx = i_balance;
                    state_nx     = DISPENSE;
                end
            end
            DISPENSE: begin
                if (remaining >= kC0) begin
                    if (o_valid && i_ready) begin
                        remaining_nx = remaining - coin_val;
                    end
                end else begin
                    residue_nx = remaining;
                    state_nx   = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        valid_nx = (state_nx == DISPENSE) && (remaining_nx >= kC0);
        busy_nx  = (state_nx != IDLE);
        done_nx  = (state_nx == DONE);

        // Largest coin not exceeding what is left, so the subtraction cannot underflow.
        if (valid_nx) begin
            if (remaining_nx >= kC2) begin
                coin_nx = 3'b100;
            end else if (remaining_nx >= kC1) begin
                coin_nx = 3'b010;
            end else begin
                coin_nx = 3'b001;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            remaining     <= '0;
            o_residue     <= '0;
            o_return_coin <= '0;
            o_valid       <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
        end else begin
            state         <= state_nx;
            remaining     <= remaining_nx;
            o_residue     <= residue_nx;
            o_return_coin <= coin_nx;
            o_valid       <= valid_nx;
            o_busy        <= busy_nx;
            o_done        <= done_nx;
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized bench for change_dispenser: each run's coin list and residue come from
// greedy arithmetic on the requested balance and are checked cycle by cycle.
module tb_change_dispenser;

    localparam int unsigned kC0 = 100;
    localparam int unsigned kC1 = 500;
    localparam int unsigned kC2 = 1000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_start = 1'b0;
    logic [30:0] i_balance = '0;
    logic        i_ready = 1'b0;
    logic [2:0]  o_return_coin;
    logic        o_valid;
    logic        o_busy;
    logic        o_done;
    logic [30:0] o_residue;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned last_residue = 0;

    change_dispenser dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_start      (i_start),
        .i_balance    (i_balance),
        .i_ready      (i_ready),
        .o_return_coin(o_return_coin),
        .o_valid      (o_valid),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_residue    (o_residue)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_valid"}, 32'(o_valid), 32'd0);
        check({tag, "_coin"}, 32'(o_return_coin), 32'd0);
    endtask

    // One full run; stall forces the first coin to wait that many cycles, ready_pct
    // sets acceptance odds afterwards, inject pulses ignored i_start requests mid-run.
    task automatic run(input int unsigned bal, input int unsigned ready_pct,
                       input int unsigned stall, input bit inject);
        int unsigned r;
        int unsigned idx;
        int unsigned val;
        int unsigned waited;
        int unsigned stall_left;
        bit          rdy;
        check("idle_busy", 32'(o_busy), 32'd0);
        i_start   = 1'b1;
        i_balance = 31'(bal);
        tick();
        i_start    = 1'b0;
        r          = bal;
        stall_left = stall;
        while (r >= kC0) begin
            idx = (r >= kC2) ? 2 : (r >= kC1) ? 1 : 0;
            val = (idx == 2) ? kC2 : (idx == 1) ? kC1 : kC0;
            waited = 0;
            forever begin
                check("coin_valid", 32'(o_valid), 32'd1);
                check("coin_onehot", 32'(o_return_coin), 32'(1 << idx));
                check("coin_busy", 32'(o_busy), 32'd1);
                check("coin_done", 32'(o_done), 32'd0);
                if (stall_left > 0) begin
                    rdy = 1'b0;
                    stall_left--;
                end else begin
                    rdy = ($urandom_range(0, 99) < ready_pct) || (waited >= 40);
                end
                i_ready = rdy;
                if (inject && ($urandom_range(0, 3) == 0)) begin
                    i_start   = 1'b1;
                    i_balance = 31'(9999);
                end else begin
                    i_start = 1'b0;
                end
                tick();
                i_start = 1'b0;
                waited++;
                if (rdy) break;
            end
            r = r - val;
        end
        i_ready = 1'($urandom_range(0, 1));
        i_start = inject;
        i_balance = 31'(9999);
        check_quiet("tail");
        check("tail_busy", 32'(o_busy), 32'd1);
        check("tail_done", 32'(o_done), 32'd0);
        check("tail_residue_held", 32'(o_residue), 32'(last_residue));
        tick();
        check_quiet("done");
        check("done_pulse", 32'(o_done), 32'd1);
        check("done_busy", 32'(o_busy), 32'd1);
        check("done_residue", 32'(o_residue), 32'(r));
        tick();
        i_start = 1'b0;
        check_quiet("after");
        check("after_done", 32'(o_done), 32'd0);
        check("after_busy", 32'(o_busy), 32'd0);
        check("after_residue", 32'(o_residue), 32'(r));
        last_residue = r;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #3;
        check_quiet("rst");
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_residue", 32'(o_residue), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // Directed cases from the requirement list.
        run(1600, 100, 0, 1'b0);
        run(2750, 100, 0, 1'b0);
        run(500, 100, 4, 1'b0);
        run(0, 100, 0, 1'b0);
        run(1700, 100, 0, 1'b1);
        run(99, 100, 0, 1'b0);
        run(100, 100, 0, 1'b0);

        // Reset mid-run after the first coin (1000) of 1100 is taken.
        i_start   = 1'b1;
        i_balance = 31'(1100);
        tick();
        i_start = 1'b0;
        check("mr_first", 32'(o_return_coin), 32'd4);
        i_ready = 1'b1;
        tick();
        check("mr_second", 32'(o_return_coin), 32'd1);
        reset_n = 1'b0;
        #1;
        check_quiet("mr_rst");
        check("mr_busy", 32'(o_busy), 32'd0);
        check("mr_residue", 32'(o_residue), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mr_no_done", 32'(o_done), 32'd0);
            check_quiet("mr_hold");
        end
        reset_n = 1'b1;
        last_residue = 0;
        tick();
        check("mr_idle_wait", 32'(o_busy), 32'd0);
        check_quiet("mr_idle");
        run(100, 100, 0, 1'b0);

        // Randomized runs.
        for (int n = 0; n < 60; n++) begin
            run($urandom_range(0, 6000), $urandom_range(20, 100),
                $urandom_range(0, 2), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
